// File: rtl/result_gather.sv
// Drains one result row from each of the 4 data-memory banks and streams the
// elements row-major on a valid/ready port, with a 2-entry skid FIFO behind the reads.
module result_gather #(
  parameter int N        = 4,
  parameter int RES_BASE = 24,
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int CW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] dataout_a,
  input  logic [DW-1:0] dataout_b,
  input  logic [DW-1:0] dataout_c,
  input  logic [DW-1:0] dataout_d,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_row,
  output logic [CW-1:0] out_col,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          done,
  output logic [1:0]    dbg_state
);

  // Output handshake: an element transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid never drops and the element never changes
  // until that transfer happens.

  localparam int TOT = 4 * N;
  localparam int RCW = $clog2(TOT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      irow_q, irow_d;
  logic [CW-1:0]   icol_q, icol_d;
  logic [RCW-1:0]  issued_q, issued_d;
  logic [RCW-1:0]  acc_q, acc_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      inf_row_q, inf_row_d;
  logic [CW-1:0]   inf_col_q, inf_col_d;
  logic [DW-1:0]   fd_q [2];
  logic [DW-1:0]   fd_d [2];
  logic [1:0]      fr_q [2];
  logic [1:0]      fr_d [2];
  logic [CW-1:0]   fc_q [2];
  logic [CW-1:0]   fc_d [2];
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic [1:0]      cnt_q, cnt_d;

  logic            pop;
  logic            issue;
  logic [2:0]      occ;
  logic [DW-1:0]   cap_data;

  always_comb begin
    cap_data = dataout_a;
    case (inf_row_q)
      2'd0:    cap_data = dataout_a;
      2'd1:    cap_data = dataout_b;
      2'd2:    cap_data = dataout_c;
      default: cap_data = dataout_d;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    irow_d     = irow_q;
    icol_d     = icol_q;
    issued_d   = issued_q;
    acc_d      = acc_q;
    inf_row_d  = inf_row_q;
    inf_col_d  = inf_col_q;
    fd_d       = fd_q;
    fr_d       = fr_q;
    fc_d       = fc_q;
    wr_d       = wr_q;
    rd_d       = rd_q;

    pop = (cnt_q != 2'd0) && out_ready;
    // The slot freed by this cycle's pop counts as credit, otherwise the read
    // pipeline stalls every other cycle and 1 element/cycle is unreachable.
    occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue = (state_q == S_RUN) && (issued_q < RCW'(TOT)) && (occ < 3'd2);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          irow_d   = 2'd0;
          icol_d   = '0;
          issued_d = '0;
          acc_d    = '0;
        end
      end
      S_RUN: begin
        if (pop && (acc_q == RCW'(TOT - 1))) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    inflight_d = issue;
    if (issue) begin
      inf_row_d = irow_q;
      inf_col_d = icol_q;
      issued_d  = issued_q + 1'b1;
      if (icol_q == CW'(N - 1)) begin
        icol_d = '0;
        irow_d = irow_q + 2'd1;
      end else begin
        icol_d = icol_q + 1'b1;
      end
    end

    if (inflight_q) begin
      fd_d[wr_q] = cap_data;
      fr_d[wr_q] = inf_row_q;
      fc_d[wr_q] = inf_col_q;
      wr_d       = ~wr_q;
    end
    if (pop) begin
      rd_d  = ~rd_q;
      acc_d = acc_q + 1'b1;
    end
    cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      irow_q     <= 2'd0;
      icol_q     <= '0;
      issued_q   <= '0;
      acc_q      <= '0;
      inflight_q <= 1'b0;
      inf_row_q  <= 2'd0;
      inf_col_q  <= '0;
      fd_q       <= '{default: '0};
      fr_q       <= '{default: '0};
      fc_q       <= '{default: '0};
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      irow_q     <= irow_d;
      icol_q     <= icol_d;
      issued_q   <= issued_d;
      acc_q      <= acc_d;
      inflight_q <= inflight_d;
      inf_row_q  <= inf_row_d;
      inf_col_q  <= inf_col_d;
      fd_q       <= fd_d;
      fr_q       <= fr_d;
      fc_q       <= fc_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;
  assign mem_addr  = AW'(RES_BASE) + AW'(icol_q);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? fd_q[rd_q] : '0;
  assign out_row   = out_valid ? fr_q[rd_q] : 2'd0;
  assign out_col   = out_valid ? fc_q[rd_q] : '0;

endmodule

// File: tb/tb_result_gather.sv
// Randomised drain scenarios for result_gather against a queue-based model of
// the expected row-major element stream built straight from the bank contents.
module tb_result_gather;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, start2;
  logic        busy, busy2;
  logic [15:0] mem_addr, mem_addr2;
  logic [15:0] da, db, dc, dd, d2a, d2b, d2c, d2d;
  logic [15:0] out_data, out_data2;
  logic [1:0]  out_row, out_row2;
  logic [1:0]  out_col;
  logic [0:0]  out_col2;
  logic        out_valid, out_valid2;
  logic        out_ready, out_ready2;
  logic        done, done2;
  logic [1:0]  dbg_state, dbg_state2;

  always #5 clock = ~clock;

  result_gather dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .mem_addr(mem_addr),
    .dataout_a(da), .dataout_b(db), .dataout_c(dc), .dataout_d(dd),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
    .out_ready(out_ready), .done(done), .dbg_state(dbg_state)
  );

  result_gather #(.N(2), .RES_BASE(40)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .busy(busy2), .mem_addr(mem_addr2),
    .dataout_a(d2a), .dataout_b(d2b), .dataout_c(d2c), .dataout_d(d2d),
    .out_data(out_data2), .out_row(out_row2), .out_col(out_col2), .out_valid(out_valid2),
    .out_ready(out_ready2), .done(done2), .dbg_state(dbg_state2)
  );

  // Banks with 1-cycle registered read ports
  logic [15:0] mem  [4][64];
  logic [15:0] mem2 [4][64];

  always @(posedge clock) begin
    da  <= mem[0][mem_addr[5:0]];
    db  <= mem[1][mem_addr[5:0]];
    dc  <= mem[2][mem_addr[5:0]];
    dd  <= mem[3][mem_addr[5:0]];
    d2a <= mem2[0][mem_addr2[5:0]];
    d2b <= mem2[1][mem_addr2[5:0]];
    d2c <= mem2[2][mem_addr2[5:0]];
    d2d <= mem2[3][mem_addr2[5:0]];
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int r, input int c, input logic [15:0] d);
    return {8'(r), 8'(c), d};
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];

  task automatic load_expected();
    exp_q.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back(pack(r, c, mem[r][24 + c]));
  endtask

  // Scoreboard / monitor for the default instance
  int          cyc = 0;
  int          beats, done_cnt, start_cyc, first_valid_cyc, first_acc_cyc, last_acc_cyc;
  bit          mon_en = 1'b0;
  bit          held_v, done_due;
  logic [31:0] held_val;

  always @(negedge clock) begin
    logic [31:0] got;
    cyc++;
    got = {8'(out_row), 8'(out_col), out_data};
    if (!reset_n || !mon_en) begin
      held_v   = 1'b0;
      done_due = 1'b0;
    end else begin
      if (start && !busy) start_cyc = cyc;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done_due) check("done_pulse", 32'(done), 32'd1);
      else if (done) check("done_early", 32'(done), 32'd0);
      if (done) done_cnt++;
      done_due = 1'b0;
      if (held_v) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", got, held_val);
      end
      if (out_valid && out_ready) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        beats++;
        if (exp_q.size() == 0) check("extra_beat", got, 32'hdead_beef);
        else begin
          check("beat", got, exp_q.pop_front());
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end
      held_v   = out_valid && !out_ready;
      held_val = got;
    end
  end

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return c >= 20;
    endcase
  endfunction

  // mode: 0 ready=1, 1 toggle, 2 random, 3 stall 20 cycles; restart_at / rst_at < 0 disables
  task automatic run_drain(input int mode, input int restart_at, input int rst_at);
    bit again;
    load_expected();
    beats = 0; done_cnt = 0; first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
    start_cyc = -1;
    again = 1'b0;
    mon_en = 1'b1;
    @(posedge clock); #1;
    start = 1'b1;
    out_ready = ready_for(mode, 0);
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c < 300; c++) begin
      if (c == 1) check("busy_run", 32'(busy), 32'd1);
      if (mode == 3 && c == 20) begin
        check("stall_addr", 32'(mem_addr), 32'd26);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(exp_q[0][15:0]));
        check("stall_beats", 32'(beats), 32'd0);
      end
      if (restart_at >= 0 && beats == restart_at && !again) begin
        start = 1'b1;
        again = 1'b1;
      end else start = 1'b0;
      if (rst_at >= 0 && beats == rst_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_out", {8'(out_row), 8'(out_col), out_data}, 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd24);
        exp_q.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        start = 1'b0;
        return;
      end
      out_ready = ready_for(mode, c);
      if (done_cnt > 0) break;
      @(posedge clock); #1;
    end
    start = 1'b0;
    check("drain_timeout", 32'(done_cnt > 0), 32'd1);
    repeat (3) @(posedge clock);
    #1;
    check("beat_count", 32'(beats), 32'd16);
    check("done_count", 32'(done_cnt), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int d2, b2;
    bit due2;
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; out_ready = 1'b0; out_ready2 = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int a = 0; a < 64; a++) begin
        mem[r][a]  = 16'($urandom);
        mem2[r][a] = 16'($urandom);
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mem[r][24 + c] = 16'(r * 4 + c + 1);
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd24);
    check("rst_out", {8'(out_row), 8'(out_col), out_data}, 32'd0);
    reset_n = 1'b1;

    // Full speed: 16 back-to-back beats, first valid 2 edges after the start edge
    run_drain(0, -1, -1);
    check("first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd3);
    check("burst_span", 32'(last_acc_cyc - first_acc_cyc), 32'd15);

    run_drain(1, -1, -1);
    run_drain(3, -1, -1);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mem[r][24 + c] = 16'($urandom);
    run_drain(2, 5, -1);
    run_drain(0, -1, 7);
    run_drain(2, -1, -1);
    check("restart_first", 32'(first_acc_cyc >= 0), 32'd1);

    // Second geometry: N=2 at base 40
    mon_en = 1'b0;
    exp2_q.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 2; c++) exp2_q.push_back(pack(r, c, mem2[r][40 + c]));
    d2 = 0; b2 = 0; due2 = 1'b0;
    @(posedge clock); #1;
    start2 = 1'b1;
    @(posedge clock); #1;
    start2 = 1'b0;
    for (int c = 0; c < 200 && d2 == 0; c++) begin
      out_ready2 = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (mem_addr2 != 16'd40 && mem_addr2 != 16'd41) check("n2_addr", 32'(mem_addr2), 32'd40);
      if (due2) check("n2_done_pulse", 32'(done2), 32'd1);
      due2 = 1'b0;
      if (done2) d2++;
      if (out_valid2 && out_ready2) begin
        b2++;
        if (exp2_q.size() == 0) check("n2_extra", {8'(out_row2), 8'(out_col2), out_data2}, 32'hdead_beef);
        else begin
          check("n2_beat", {8'(out_row2), 8'(out_col2), out_data2}, exp2_q.pop_front());
          if (exp2_q.size() == 0) due2 = 1'b1;
        end
      end
      @(posedge clock); #1;
    end
    repeat (3) begin
      @(negedge clock);
      if (done2) d2++;
    end
    check("n2_beats", 32'(b2), 32'd8);
    check("n2_done_count", 32'(d2), 32'd1);
    check("n2_idle_addr", 32'(mem_addr2), 32'd40);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
